// File: rtl/mult32_seq_pkg.sv
// mult32_seq_pkg: shared state encoding and step/latency constants for the sequential multiplier
package mult32_seq_pkg;
  localparam int MULT_STEPS = 32;
  localparam int MULT_LATENCY = 35;
  typedef enum logic [2:0] {ST_IDLE, ST_CALC, ST_NEG_LO, ST_NEG_HI, ST_DONE} state_t;
endpackage

// File: rtl/mult32_seq_if.sv
// mult32_seq_if: request/result bundle between the issue stage (master) and the multiplier (slave)
interface mult32_seq_if;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, is_signed, a, b, input busy, done, hi, lo);
  modport slave (input start, is_signed, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mult32_seq_full_add32.sv
// mult32_seq_full_add32: 32-bit adder with carry in/out, shared by every sum in the multiplier
module mult32_seq_full_add32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {32'd0, i_cin};
endmodule

// File: rtl/mult32_seq.sv
// mult32_seq: fixed-latency 32x32->64 shift-and-add multiplier (MULT/MULTU) producing HI/LO
module mult32_seq
  import mult32_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  mult32_seq_if.slave bus
);
  state_t      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_mcand, r_ph, r_pl, r_hi, r_lo;
  logic        r_neg, r_carry, r_busy, r_done;
  logic [31:0] w_x, w_y, w_sum, w_mplier;
  logic        w_ci, w_co;
  logic [32:0] w_s;
  // Idle cycles borrow the adder to form |a| as ~a + 1
  always_comb begin
    w_x = r_state == ST_CALC ? r_ph : r_state == ST_NEG_LO ? ~r_pl : r_state == ST_NEG_HI ? ~r_ph : ~bus.a;
    w_y = r_state == ST_CALC ? r_mcand : 32'd0;
    w_ci = r_state == ST_CALC ? 1'b0 : r_state == ST_NEG_HI ? r_carry : 1'b1;
    w_s = r_pl[0] ? {w_co, w_sum} : {1'b0, r_ph};
    w_mplier = bus.is_signed && bus.b[31] ? ~bus.b + 32'd1 : bus.b;
  end
  mult32_seq_full_add32 u_add (.i_a(w_x), .i_b(w_y), .i_cin(w_ci), .o_sum(w_sum), .o_cout(w_co));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt <= '0;
      r_mcand <= '0;
      r_ph <= '0;
      r_pl <= '0;
      r_hi <= '0;
      r_lo <= '0;
      r_neg <= 1'b0;
      r_carry <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        ST_CALC: begin
          r_ph <= w_s[32:1];
          r_pl <= {w_s[0], r_pl[31:1]};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(MULT_STEPS - 1)) r_state <= ST_NEG_LO;
        end
        ST_NEG_LO: begin
          r_lo <= r_neg ? w_sum : r_pl;
          r_carry <= w_co;
          r_state <= ST_NEG_HI;
        end
        ST_NEG_HI: begin
          r_hi <= r_neg ? w_sum : r_ph;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_state <= ST_DONE;
        end
        default: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_mcand <= bus.is_signed && bus.a[31] ? w_sum : bus.a;
            r_pl <= w_mplier;
            r_ph <= '0;
            r_neg <= bus.is_signed && (bus.a[31] ^ bus.b[31]);
            r_cnt <= '0;
            r_busy <= 1'b1;
            r_state <= ST_CALC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi = r_hi;
  assign bus.lo = r_lo;
endmodule

// File: tb/tb_mult32_seq.sv
// tb_mult32_seq: directed and randomized checks of mult32_seq against a 64-bit arithmetic model
module tb_mult32_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  mult32_seq_if bus ();
  mult32_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (!s) return {32'd0, a} * {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and waits for done; lat is the cycle index of done (0 on timeout)
  task automatic run_mult(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat, output int busy_bad);
    int n;
    bus.start = 1'b1;
    bus.is_signed = s;
    bus.a = a;
    bus.b = b;
    step();
    bus.start = 1'b0;
    n = 1;
    busy_bad = 0;
    while (!bus.done && n < 40) begin
      if (bus.busy !== 1'b1) busy_bad++;
      step();
      n++;
    end
    lat = bus.done ? n : 0;
    if (bus.busy !== 1'b0) busy_bad++;
    res = {bus.hi, bus.lo};
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = 32'd0;
    bus.b = 32'd0;
    rst_n = 1'b0;
    step();
    step();
    n_cmp += 4;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL reset_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL reset_lo got %h want 0", bus.lo); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    logic        ts[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] ta[7] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd0};
    logic [31:0] tb[7] = '{32'd5, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd1, 32'h80000000};
    logic [63:0] te[7] = '{64'h0000000F, 64'hFFFFFFFE_00000001, 64'hFFFFFFFF_FFFFFFF1, 64'h1,
                           64'h40000000_00000000, 64'hFFFFFFFF_80000000, 64'h0};
    logic [63:0] res;
    int lat, bb;
    for (int i = 0; i < 7; i++) begin
      run_mult(ts[i], ta[i], tb[i], res, lat, bb);
      n_cmp += 3;
      if (res !== te[i]) begin n_bad++; $display("FAIL directed%0d product got %h want %h", i, res, te[i]); end
      if (lat !== 35) begin n_bad++; $display("FAIL directed%0d latency got %0d want 35", i, lat); end
      if (bb !== 0) begin n_bad++; $display("FAIL directed%0d busy_profile got %0d bad cycles want 0", i, bb); end
      step();
    end
  endtask

  task automatic test_ignore_start();
    int n, lat, extra;
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = 32'd7;
    bus.b = 32'd6;
    step();
    bus.start = 1'b0;
    n = 1;
    while (n < 10) begin step(); n++; end
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    step();
    n++;
    bus.start = 1'b0;
    while (!bus.done && n < 40) begin step(); n++; end
    lat = bus.done ? n : 0;
    n_cmp += 3;
    if (lat !== 35) begin n_bad++; $display("FAIL ignore_latency got %0d want 35", lat); end
    if ({bus.hi, bus.lo} !== 64'd42) begin n_bad++; $display("FAIL ignore_product got %h want 42", {bus.hi, bus.lo}); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin step(); if (bus.done) extra++; end
    if (extra !== 0) begin n_bad++; $display("FAIL ignore_extra_done got %0d want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, bb;
    run_mult(1'b0, 32'd3, 32'd5, res, lat, bb);
    run_mult(1'b1, 32'hFFFFFFFD, 32'd5, res, lat, bb);
    n_cmp += 2;
    if (lat !== 35) begin n_bad++; $display("FAIL b2b_latency got %0d want 35", lat); end
    if (res !== 64'hFFFFFFFF_FFFFFFF1) begin n_bad++; $display("FAIL b2b_product got %h want fffffffffffffff1", res); end
    step();
  endtask

  task automatic test_mid_reset();
    int dones;
    bus.start = 1'b1;
    bus.is_signed = 1'b0;
    bus.a = 32'h12345678;
    bus.b = 32'h9ABCDEF0;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) step();
    rst_n = 1'b0;
    step();
    n_cmp += 5;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", bus.done); end
    if (bus.hi !== 32'd0) begin n_bad++; $display("FAIL midrst_hi got %h want 0", bus.hi); end
    if (bus.lo !== 32'd0) begin n_bad++; $display("FAIL midrst_lo got %h want 0", bus.lo); end
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin step(); if (bus.done || bus.busy) dones++; end
    if (dones !== 0) begin n_bad++; $display("FAIL midrst_activity got %0d cycles want 0", dones); end
  endtask

  task automatic test_random();
    logic [63:0] res, exp_v;
    logic [31:0] a, b;
    bit s;
    int lat, bb;
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      a = (i % 16 == 0) ? 32'h80000000 : $urandom;
      b = (i % 16 == 8) ? 32'hFFFFFFFF : $urandom;
      exp_v = model(s, a, b);
      run_mult(s, a, b, res, lat, bb);
      n_cmp += 2;
      if (res !== exp_v) begin n_bad++; $display("FAIL rand%0d s=%0d a=%h b=%h got %h want %h", i, s, a, b, res, exp_v); end
      if (lat !== 35 || bb !== 0) begin n_bad++; $display("FAIL rand%0d timing latency %0d busy_bad %0d want 35/0", i, lat, bb); end
      if (i % 3 == 0) step();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
